// File: rtl/logic_result_collector.sv
// Packs a 1-bit result stream into WIDTH-bit words with popcount over valid/ready.
// Optional parity output enabled by defining LOGIC_RESULT_COLLECTOR_PARITY_EN.
module logic_result_collector #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned LSB_FIRST = 1
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         bit_in,
   input  logic                         bit_valid,
   output logic                         bit_ready,
   output logic [WIDTH-1:0]             word_out,
   output logic [$clog2(WIDTH+1)-1:0]   ones_count,
   output logic                         word_valid,
   input  logic                         out_ready
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
   ,
   output logic                         parity_out
`endif
);

   localparam int unsigned CNTW = $clog2(WIDTH);
   localparam int unsigned CW   = $clog2(WIDTH+1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("logic_result_collector: WIDTH must be in 2..32");
   end

   typedef enum logic {FILL, FULL} state_t;

   state_t            state_q;
   logic [CNTW-1:0]   cnt_q;
   logic [WIDTH-1:0]  shift_q;
   logic [WIDTH-1:0]  word_q;
   logic [CW-1:0]     ones_q;
   logic              valid_q;
   logic              ready_q;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
   logic              parity_q;
`endif

   logic [CNTW-1:0]   idx_c;
   logic [WIDTH-1:0]  asm_c;
   logic [WIDTH-1:0]  load_c;
   logic [CW-1:0]     ones_c;
   logic              accept_c;
   logic              last_c;

   // Assembled word with the incoming bit placed, and the word that a load would capture
   always_comb begin
      idx_c    = (LSB_FIRST != 0) ? cnt_q : CNTW'(WIDTH-1) - cnt_q;
      asm_c    = shift_q;
      asm_c[idx_c] = bit_in;
      load_c   = (state_q == FULL) ? shift_q : asm_c;
      ones_c   = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         ones_c = ones_c + CW'(load_c[i]);
      end
      accept_c = bit_valid && ready_q;
      last_c   = (cnt_q == CNTW'(WIDTH-1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= FILL;
         cnt_q    <= '0;
         shift_q  <= '0;
         word_q   <= '0;
         ones_q   <= '0;
         valid_q  <= 1'b0;
         ready_q  <= 1'b1;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            FILL: begin
               if (valid_q && out_ready) begin
                  valid_q <= 1'b0;
               end
               if (accept_c) begin
                  if (last_c) begin
                     cnt_q <= '0;
                     if (!valid_q || out_ready) begin
                        // Reload overrides the pop so the output never bubbles
                        word_q   <= load_c;
                        ones_q   <= ones_c;
                        valid_q  <= 1'b1;
                        shift_q  <= '0;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
                        parity_q <= ^load_c;
`endif
                     end else begin
                        shift_q <= asm_c;
                        state_q <= FULL;
                        ready_q <= 1'b0;
                     end
                  end else begin
                     shift_q <= asm_c;
                     cnt_q   <= cnt_q + CNTW'(1);
                  end
               end
            end
            FULL: begin
               if (out_ready) begin
                  word_q   <= load_c;
                  ones_q   <= ones_c;
                  valid_q  <= 1'b1;
                  shift_q  <= '0;
                  cnt_q    <= '0;
                  state_q  <= FILL;
                  ready_q  <= 1'b1;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
                  parity_q <= ^load_c;
`endif
               end
            end
            default: begin
               state_q <= FILL;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign bit_ready  = ready_q;
   assign word_out   = word_q;
   assign ones_count = ones_q;
   assign word_valid = valid_q;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
   assign parity_out = parity_q;
`endif

endmodule

// File: tb/tb_logic_result_collector.sv
// Bench for logic_result_collector: cycle compare against a word-level model plus directed literals.
module tb_logic_result_collector;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       bit_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       out_ready = 1'b1;
   logic       bit_ready, word_valid, bit_ready1, word_valid1;
   logic [7:0] word_out, word_out1;
   logic [3:0] ones_count, ones_count1;
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
   logic       parity_out, parity_out1;
`endif

   int checks = 0;
   int errors = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   logic_result_collector #(.WIDTH(8), .LSB_FIRST(1)) u0 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready), .word_out(word_out), .ones_count(ones_count),
      .word_valid(word_valid), .out_ready(out_ready)
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
      , .parity_out(parity_out)
`endif
   );

   // MSB-first twin: always drained, so it sees the same bit stream as u0
   logic_result_collector #(.WIDTH(8), .LSB_FIRST(0)) u1 (
      .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid),
      .bit_ready(bit_ready1), .word_out(word_out1), .ones_count(ones_count1),
      .word_valid(word_valid1), .out_ready(1'b1)
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
      , .parity_out(parity_out1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level model of u0: bits collected, an optional held word, and the output slot
   int         m_cnt = 0;
   logic [7:0] m_asm = '0;
   bit         m_full = 1'b0;
   logic [7:0] m_word = '0;
   bit         m_valid = 1'b0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0; m_asm = '0; m_full = 1'b0; m_word = '0; m_valid = 1'b0;
      end else if (m_full) begin
         if (out_ready) begin
            m_word = m_asm; m_valid = 1'b1; m_full = 1'b0; m_cnt = 0;
         end
      end else begin
         bit popped;
         popped = m_valid && out_ready;
         if (bit_valid) begin
            m_asm[m_cnt] = bit_in;
            m_cnt++;
         end
         if (m_cnt == 8) begin
            m_cnt = 0;
            if (!m_valid || out_ready) begin
               m_word = m_asm; m_valid = 1'b1;
            end else begin
               m_full = 1'b1;
            end
         end else if (popped) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("cyc_word_valid", 32'(word_valid), 32'(m_valid));
         chk("cyc_bit_ready", 32'(bit_ready), 32'(!m_full));
         chk("cyc_word_out", 32'(word_out), 32'(m_word));
         chk("cyc_ones_count", 32'(ones_count), 32'($countones(m_word)));
`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
         chk("cyc_parity", 32'(parity_out), 32'(^m_word));
`endif
      end
   end

   // Present n bits of w, LSB first, one per cycle; returns 1 time unit after the last edge
   task automatic drive_bits(input logic [7:0] w, input int n);
      for (int i = 0; i < n; i++) begin
         bit_valid = 1'b1;
         bit_in    = w[i];
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      bit_in    = 1'b0;
   endtask

   initial begin
      logic [7:0] w2;
      #2 rst = 1'b1;
      chk_en = 1'b1;
      #6;
      chk("rst_word_valid", 32'(word_valid), 32'd0);
      chk("rst_bit_ready", 32'(bit_ready), 32'd1);
      chk("rst_word_out", 32'(word_out), 32'd0);
      #14 rst = 1'b0;
      @(posedge clk); #1;

      // Bits 1,0,1,1,0,0,0,1 with the consumer always ready
      out_ready = 1'b1;
      drive_bits(8'h8D, 8);
      chk("t1_valid", 32'(word_valid), 32'd1);
      chk("t1_word", 32'(word_out), 32'h8D);
      chk("t1_ones", 32'(ones_count), 32'd4);
      chk("t1_model_word", 32'(m_word), 32'h8D);
      chk("t1_msb_first_word", 32'(word_out1), 32'hB1);
      @(posedge clk); #1;
      chk("t1_valid_drop", 32'(word_valid), 32'd0);

      // Backpressure: second word parks in the assembly register
      out_ready = 1'b0;
      drive_bits(8'hFF, 8);
      drive_bits(8'h00, 8);
      chk("t2_word_held", 32'(word_out), 32'hFF);
      chk("t2_ones_held", 32'(ones_count), 32'd8);
      chk("t2_valid_held", 32'(word_valid), 32'd1);
      chk("t2_ready_low", 32'(bit_ready), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk("t2_word_still", 32'(word_out), 32'hFF);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("t2_word_swap", 32'(word_out), 32'h00);
      chk("t2_ones_swap", 32'(ones_count), 32'd0);
      chk("t2_valid_swap", 32'(word_valid), 32'd1);
      chk("t2_ready_back", 32'(bit_ready), 32'd1);

      // Asynchronous reset in the middle of a word
      drive_bits(8'hFF, 3);
      #2 rst = 1'b1;
      #1;
      chk("t3_rst_valid", 32'(word_valid), 32'd0);
      chk("t3_rst_ready", 32'(bit_ready), 32'd1);
      chk("t3_rst_word", 32'(word_out), 32'd0);
      #3 rst = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b1;
      drive_bits(8'h55, 8);
      chk("t3_word", 32'(word_out), 32'h55);
      chk("t3_ones", 32'(ones_count), 32'd4);

      // Back-to-back: last bit of 8'h3C lands on the cycle 8'hA5 is popped
      drive_bits(8'hA5, 8);
      chk("t4_first", 32'(word_out), 32'hA5);
      out_ready = 1'b0;
      w2 = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         bit_valid = 1'b1;
         bit_in    = w2[i];
         out_ready = (i == 7);
         @(posedge clk); #1;
         chk("t4_no_gap", 32'(word_valid), 32'd1);
         if (i < 7) chk("t4_old_word", 32'(word_out), 32'hA5);
      end
      bit_valid = 1'b0;
      chk("t4_second", 32'(word_out), 32'h3C);
      chk("t4_second_ones", 32'(ones_count), 32'd4);
      @(posedge clk); #1;
      chk("t4_drained", 32'(word_valid), 32'd0);

      // MSB-first placement: first bit 1 then seven zeros
      drive_bits(8'h01, 8);
      chk("t5_msb_word", 32'(word_out1), 32'h80);
      chk("t5_msb_ones", 32'(ones_count1), 32'd1);
      chk("t5_lsb_word", 32'(word_out), 32'h01);

`ifdef LOGIC_RESULT_COLLECTOR_PARITY_EN
      drive_bits(8'h07, 8);
      chk("t6_parity_07", 32'(parity_out), 32'd1);
      drive_bits(8'h03, 8);
      chk("t6_parity_03", 32'(parity_out), 32'd0);
`endif

      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
